mem_port_arbiter: RTL

- Shares the single backing-memory port between the ICache miss path and the DCache miss/writeback path.
- Serialises whole-line burst transfers, one word per beat, and returns per-requester response beats.
- Drives the ICacheMiss/DCacheMiss stall inputs of the hazard unit through its pending flags.
- Sits in the memory subsystem between the two caches and main memory.

---
 rtl/mem_if_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the backing-memory port arbiter.
// Holds the arbiter state encoding, the requester identifiers, and the
// line-base helper that clears the word/byte offset bits of an address.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_I = 2'd1,
    SERV_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Clear the low lsb_bits of an address (up to 64 bits wide).
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int lsb_bits);
    logic [63:0] mask;
    mask = (64'd1 << lsb_bits) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter for the ICache (req_i) and DCache (req_d)
// requesters. Grants are combinational while en is high; the last_grant
// register remembers the winner so a tie goes to the other side next time.
// Ports: clk, rst (sync active-high), en, req_i, req_d -> gnt_i, gnt_d.
module rr_arbiter2
  import mem_if_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  logic last_grant;

  // Grant selection: single requester wins outright, a tie goes opposite last_grant.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (req_i && req_d) begin
        if (last_grant == REQ_I) begin
          gnt_d = 1'b1;
        end else begin
          gnt_i = 1'b1;
        end
      end else if (req_i) begin
        gnt_i = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end else begin
        gnt_i = 1'b0;
      end
    end else begin
      gnt_d = 1'b0;
    end
  end

  // Remember the most recent winner; reset value lets DCache take the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_I;
    end else if (gnt_i) begin
      last_grant <= REQ_I;
    end else if (gnt_d) begin
      last_grant <= REQ_D;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the ICache miss path and the
// DCache miss/writeback path. Each accepted request becomes a whole-line
// burst, one word per beat, with a registered response beat per ack.
// Ports:
//   CPU_CLK, CPU_RST         clock, synchronous active-high reset
//   ireq_* / irsp_*          ICache line-fill request and read beats
//   dreq_* / drsp_*, d_beat  DCache fill/writeback request, beats, beat index
//   icache_pending, dcache_pending  stall flags for the hazard unit
//   mem_*                    backing-memory beat interface (req held until ack)
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int WORD_OFF   = 2,
  localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              ireq_ready,
  output logic              irsp_valid,
  output logic [31:0]       irsp_data,
  output logic              irsp_last,
  input  logic              dreq_valid,
  input  logic              dreq_we,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [31:0]       dreq_wdata,
  output logic              dreq_ready,
  output logic              drsp_valid,
  output logic [31:0]       drsp_data,
  output logic              drsp_last,
  output logic [BEAT_W-1:0] d_beat,
  output logic              icache_pending,
  output logic              dcache_pending,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [63:0]        MASK64    = line_base({64{1'b1}}, BEAT_W + WORD_OFF);
  localparam logic [ADDR_W-1:0]  LINE_MASK = MASK64[ADDR_W-1:0];
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] base;
  logic              we_lat;
  logic [BEAT_W-1:0] beat;
  logic              served;
  logic              arb_en;
  logic              gnt_i;
  logic              gnt_d;
  logic              in_serv;

  // Arbitration is only live in IDLE and never while reset is asserted.
  assign arb_en  = (state == IDLE) && !CPU_RST;
  assign in_serv = (state == SERV_I) || (state == SERV_D);

  rr_arbiter2 u_rr (
    .clk   (CPU_CLK),
    .rst   (CPU_RST),
    .en    (arb_en),
    .req_i (ireq_valid),
    .req_d (dreq_valid),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  // FSM state register.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the same-cycle ready pulses.
  always_comb begin
    state_next = state;
    ireq_ready = 1'b0;
    dreq_ready = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_i) begin
          ireq_ready = 1'b1;
          state_next = SERV_I;
        end else if (gnt_d) begin
          dreq_ready = 1'b1;
          state_next = SERV_D;
        end else begin
          state_next = IDLE;
        end
      end
      SERV_I, SERV_D: begin
        if (mem_ack && (beat == LAST_BEAT)) begin
          state_next = DONE;
        end else begin
          state_next = state;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath: request latch, beat counter and registered response beats.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      base       <= {ADDR_W{1'b0}};
      we_lat     <= 1'b0;
      beat       <= {BEAT_W{1'b0}};
      served     <= REQ_I;
      irsp_valid <= 1'b0;
      irsp_data  <= 32'd0;
      irsp_last  <= 1'b0;
      drsp_valid <= 1'b0;
      drsp_data  <= 32'd0;
      drsp_last  <= 1'b0;
    end else begin
      irsp_valid <= 1'b0;
      irsp_last  <= 1'b0;
      drsp_valid <= 1'b0;
      drsp_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_i) begin
            base   <= ireq_addr & LINE_MASK;
            we_lat <= 1'b0;
            beat   <= {BEAT_W{1'b0}};
            served <= REQ_I;
          end else if (gnt_d) begin
            base   <= dreq_addr & LINE_MASK;
            we_lat <= dreq_we;
            beat   <= {BEAT_W{1'b0}};
            served <= REQ_D;
          end else begin
            beat <= {BEAT_W{1'b0}};
          end
        end
        SERV_I: begin
          if (mem_ack) begin
            irsp_valid <= 1'b1;
            irsp_data  <= mem_rdata;
            irsp_last  <= (beat == LAST_BEAT);
            // Return to zero after the final beat instead of wrapping mid-burst.
            beat       <= (beat == LAST_BEAT) ? {BEAT_W{1'b0}} : beat + BEAT_W'(1);
          end else begin
            beat <= beat;
          end
        end
        SERV_D: begin
          if (mem_ack) begin
            drsp_valid <= 1'b1;
            drsp_data  <= mem_rdata;
            drsp_last  <= (beat == LAST_BEAT);
            beat       <= (beat == LAST_BEAT) ? {BEAT_W{1'b0}} : beat + BEAT_W'(1);
          end else begin
            beat <= beat;
          end
        end
        DONE:    beat <= {BEAT_W{1'b0}};
        default: beat <= {BEAT_W{1'b0}};
      endcase
    end
  end

  // Memory-side beat drive; write data is passed straight through for D writebacks.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'd0;
    d_beat    = {BEAT_W{1'b0}};
    if (in_serv) begin
      mem_req  = 1'b1;
      mem_we   = we_lat;
      mem_addr = base + (ADDR_W'(beat) << WORD_OFF);
    end else begin
      mem_req = 1'b0;
    end
    if (state == SERV_D) begin
      d_beat = beat;
      if (we_lat) begin
        mem_wdata = dreq_wdata;
      end else begin
        mem_wdata = 32'd0;
      end
    end else begin
      d_beat = {BEAT_W{1'b0}};
    end
  end

  // Pending flags stay up through DONE so they drop the cycle after the last beat.
  always_comb begin
    icache_pending = 1'b0;
    dcache_pending = 1'b0;
    case (state)
      IDLE: begin
        icache_pending = ireq_valid && !CPU_RST;
        dcache_pending = dreq_valid && !CPU_RST;
      end
      SERV_I:  icache_pending = 1'b1;
      SERV_D:  dcache_pending = 1'b1;
      DONE: begin
        icache_pending = (served == REQ_I);
        dcache_pending = (served == REQ_D);
      end
      default: icache_pending = 1'b0;
    endcase
  end

endmodule
